// File: rtl/tlb_pkg.sv
// Shared TLB definitions: requester IDs, arbiter FSM encoding, field widths
// and the search-result record exchanged between the TLB and its clients.
package tlb_pkg;

  localparam logic [1:0] RID_IF   = 2'd0;
  localparam logic [1:0] RID_MEM  = 2'd1;
  localparam logic [1:0] RID_SRCH = 2'd2;

  localparam int VPPN_W    = 19;
  localparam int PPN_W     = 20;
  localparam int PS_W      = 6;
  localparam int ASID_W    = 10;
  localparam int PLV_W     = 2;
  localparam int MAT_W     = 2;
  localparam int TLB_IDX_W = 4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_BLOCK = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                 found;
    logic [TLB_IDX_W-1:0] index;
    logic [PPN_W-1:0]     ppn;
    logic [PS_W-1:0]      ps;
    logic [PLV_W-1:0]     plv;
    logic [MAT_W-1:0]     mat;
    logic                 d;
    logic                 v;
  } tlb_result_t;

  // One-hot grant (bit position == requester ID) to requester ID.
  function automatic logic [1:0] gnt_to_rid(input logic [2:0] gnt_oh);
    logic [1:0] rid;
    case (gnt_oh)
      3'b001:  rid = RID_IF;
      3'b010:  rid = RID_MEM;
      3'b100:  rid = RID_SRCH;
      default: rid = RID_IF;
    endcase
    return rid;
  endfunction

endpackage

// File: rtl/tlb_prio_sel.sv
// Three-way fixed-priority selector (SRCH > MEM > IF) with an override that
// lifts a starving IF above MEM. Output is one-hot, indexed by requester ID.
module tlb_prio_sel
  import tlb_pkg::*;
(
  input  logic       enable,
  input  logic       if_req,
  input  logic       mem_req,
  input  logic       srch_req,
  input  logic       if_promote,
  output logic [2:0] gnt_oh
);

  // Priority decode; SRCH always stays on top even when IF is promoted.
  always_comb begin
    gnt_oh = 3'b000;
    if (!enable) begin
      gnt_oh = 3'b000;
    end else if (srch_req) begin
      gnt_oh = 3'b100;
    end else if (if_promote && if_req) begin
      gnt_oh = 3'b001;
    end else if (mem_req) begin
      gnt_oh = 3'b010;
    end else if (if_req) begin
      gnt_oh = 3'b001;
    end else begin
      gnt_oh = 3'b000;
    end
  end

endmodule

// File: rtl/tlb_search_arbiter.sv
// Shares the single TLB search port between IF, MEM and TLBSRCH, and returns
// the registered lookup result one cycle after the grant, tagged with its owner.
module tlb_search_arbiter
  import tlb_pkg::*;
#(
  parameter int TLBNUM     = 16,
  parameter int IDX_W      = 4,
  parameter int STARVE_MAX = 3
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req,
  input  logic [18:0]      if_vppn,
  input  logic             if_va_bit12,
  output logic             if_gnt,
  input  logic             mem_req,
  input  logic [18:0]      mem_vppn,
  input  logic             mem_va_bit12,
  output logic             mem_gnt,
  input  logic             srch_req,
  input  logic [18:0]      srch_vppn,
  output logic             srch_gnt,
  input  logic [9:0]       csr_asid,
  input  logic             flush,
  input  logic             tlb_busy,
  output logic [18:0]      s_vppn,
  output logic             s_va_bit12,
  output logic [9:0]       s_asid,
  input  logic             s_found,
  input  logic [IDX_W-1:0] s_index,
  input  logic [19:0]      s_ppn,
  input  logic [5:0]       s_ps,
  input  logic [1:0]       s_plv,
  input  logic [1:0]       s_mat,
  input  logic             s_d,
  input  logic             s_v,
  output logic             rsp_valid,
  output logic [1:0]       rsp_id,
  output logic             rsp_found,
  output logic [IDX_W-1:0] rsp_index,
  output logic [19:0]      rsp_ppn,
  output logic [5:0]       rsp_ps,
  output logic [1:0]       rsp_plv,
  output logic [1:0]       rsp_mat,
  output logic             rsp_d,
  output logic             rsp_v
);

  localparam int STARVE_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);

  if (IDX_W != $clog2(TLBNUM)) begin : g_bad_idx_w
    $error("IDX_W must equal clog2(TLBNUM)");
  end

  arb_state_e            state_r;
  logic [STARVE_W-1:0]   starve_cnt_r;
  logic                  grant_en_s;
  logic                  if_promote_s;
  logic [2:0]            gnt_oh_s;
  tlb_result_t           result_s;
  tlb_result_t           rsp_r;
  logic                  rsp_valid_r;
  logic [1:0]            rsp_id_r;

  // BLOCK lingers one cycle past tlb_busy so the first grant sees the written TLB.
  assign grant_en_s   = (state_r == ST_RUN) && !tlb_busy && !flush;
  assign if_promote_s = (starve_cnt_r == STARVE_TOP);

  tlb_prio_sel u_prio_sel (
    .enable     (grant_en_s),
    .if_req     (if_req),
    .mem_req    (mem_req),
    .srch_req   (srch_req),
    .if_promote (if_promote_s),
    .gnt_oh     (gnt_oh_s)
  );

  assign if_gnt   = gnt_oh_s[RID_IF];
  assign mem_gnt  = gnt_oh_s[RID_MEM];
  assign srch_gnt = gnt_oh_s[RID_SRCH];
  assign s_asid   = csr_asid;

  // Search-port mux; idles on the IF payload when nothing is granted.
  always_comb begin
    s_vppn     = if_vppn;
    s_va_bit12 = if_va_bit12;
    if (gnt_oh_s[RID_SRCH]) begin
      s_vppn     = srch_vppn;
      s_va_bit12 = 1'b0;
    end else if (gnt_oh_s[RID_MEM]) begin
      s_vppn     = mem_vppn;
      s_va_bit12 = mem_va_bit12;
    end else begin
      s_vppn     = if_vppn;
      s_va_bit12 = if_va_bit12;
    end
  end

  assign result_s = '{
    found: s_found,
    index: TLB_IDX_W'(s_index),
    ppn:   s_ppn,
    ps:    s_ps,
    plv:   s_plv,
    mat:   s_mat,
    d:     s_d,
    v:     s_v
  };

  // RUN/BLOCK state machine tracking TLB write activity.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_RUN;
    end else begin
      case (state_r)
        ST_RUN:   state_r <= tlb_busy ? ST_BLOCK : ST_RUN;
        ST_BLOCK: state_r <= tlb_busy ? ST_BLOCK : ST_RUN;
        default:  state_r <= ST_RUN;
      endcase
    end
  end

  // IF starvation counter: counts IF losses to MEM, saturating at the promote level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_r <= '0;
    end else if (gnt_oh_s[RID_IF] || !if_req) begin
      starve_cnt_r <= '0;
    end else if (gnt_oh_s[RID_MEM] && (starve_cnt_r != STARVE_TOP)) begin
      starve_cnt_r <= starve_cnt_r + STARVE_W'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Response register: one-cycle valid pulse carrying the winner's lookup result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= 2'd0;
      rsp_r       <= '0;
    end else begin
      rsp_valid_r <= |gnt_oh_s;
      if (|gnt_oh_s) begin
        rsp_id_r <= gnt_to_rid(gnt_oh_s);
        rsp_r    <= result_s;
      end else begin
        rsp_id_r <= rsp_id_r;
        rsp_r    <= rsp_r;
      end
    end
  end

  // TLBSRCH results commit CSR state, so a flush only squashes IF/MEM responses.
  assign rsp_valid = rsp_valid_r & ~(flush & (rsp_id_r != RID_SRCH));
  assign rsp_id    = rsp_id_r;
  assign rsp_found = rsp_r.found;
  assign rsp_index = IDX_W'(rsp_r.index);
  assign rsp_ppn   = rsp_r.ppn;
  assign rsp_ps    = rsp_r.ps;
  assign rsp_plv   = rsp_r.plv;
  assign rsp_mat   = rsp_r.mat;
  assign rsp_d     = rsp_r.d;
  assign rsp_v     = rsp_r.v;

endmodule

// File: tb/tb_tlb_search_arbiter.sv
// Directed bench for tlb_search_arbiter with a tiny combinational TLB model:
// ppn = {vppn, va_bit12} ^ 20'h12365, index = vppn[3:0], ps = 12.
module tb_tlb_search_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0, mem_req = 1'b0, srch_req = 1'b0;
  logic [18:0] if_vppn = 19'h0, mem_vppn = 19'h0, srch_vppn = 19'h0;
  logic        if_va_bit12 = 1'b0, mem_va_bit12 = 1'b0;
  logic        if_gnt, mem_gnt, srch_gnt;
  logic [9:0]  csr_asid = 10'h2A5;
  logic        flush = 1'b0, tlb_busy = 1'b0;
  logic [18:0] s_vppn;
  logic        s_va_bit12;
  logic [9:0]  s_asid;
  logic        s_found, s_d, s_v;
  logic [3:0]  s_index;
  logic [19:0] s_ppn;
  logic [5:0]  s_ps;
  logic [1:0]  s_plv, s_mat;
  logic        rsp_valid, rsp_found, rsp_d, rsp_v;
  logic [1:0]  rsp_id, rsp_plv, rsp_mat;
  logic [3:0]  rsp_index;
  logic [19:0] rsp_ppn;
  logic [5:0]  rsp_ps;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    s_found = (s_vppn != 19'h7FFFF);
    s_index = s_vppn[3:0];
    s_ppn   = {s_vppn, s_va_bit12} ^ 20'h12365;
    s_ps    = 6'd12;
    s_plv   = 2'd0;
    s_mat   = 2'd1;
    s_d     = 1'b1;
    s_v     = 1'b1;
  end

  tlb_search_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_vppn(if_vppn), .if_va_bit12(if_va_bit12), .if_gnt(if_gnt),
    .mem_req(mem_req), .mem_vppn(mem_vppn), .mem_va_bit12(mem_va_bit12), .mem_gnt(mem_gnt),
    .srch_req(srch_req), .srch_vppn(srch_vppn), .srch_gnt(srch_gnt),
    .csr_asid(csr_asid), .flush(flush), .tlb_busy(tlb_busy),
    .s_vppn(s_vppn), .s_va_bit12(s_va_bit12), .s_asid(s_asid),
    .s_found(s_found), .s_index(s_index), .s_ppn(s_ppn), .s_ps(s_ps),
    .s_plv(s_plv), .s_mat(s_mat), .s_d(s_d), .s_v(s_v),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_found(rsp_found), .rsp_index(rsp_index),
    .rsp_ppn(rsp_ppn), .rsp_ps(rsp_ps), .rsp_plv(rsp_plv), .rsp_mat(rsp_mat),
    .rsp_d(rsp_d), .rsp_v(rsp_v)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({if_gnt, mem_gnt, srch_gnt, rsp_valid, rsp_id} !== 6'b0) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: got gnt=%b%b%b vld=%b id=%0d, want all 0",
                 i, if_gnt, mem_gnt, srch_gnt, rsp_valid, rsp_id);
      end
    end
    checks++;
    if ({rsp_found, rsp_ppn, rsp_ps} !== 27'h0) begin
      errors++;
      $display("FAIL reset_fields: got found=%b ppn=%h ps=%0d, want 0", rsp_found, rsp_ppn, rsp_ps);
    end
  endtask

  task automatic test_if_hit();
    tick();
    if_req = 1'b1; if_vppn = 19'h00010; if_va_bit12 = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_gnt, mem_gnt, srch_gnt} !== 3'b100) begin
      errors++;
      $display("FAIL if_gnt: got %b%b%b, want 100", if_gnt, mem_gnt, srch_gnt);
    end
    checks++;
    if (s_vppn !== 19'h00010 || s_asid !== 10'h2A5) begin
      errors++;
      $display("FAIL if_search_port: got vppn=%h asid=%h, want 00010 2a5", s_vppn, s_asid);
    end
    tick();
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_ppn !== 20'h12345 || rsp_found !== 1'b1
        || rsp_ps !== 6'd12 || rsp_index !== 4'h0) begin
      errors++;
      $display("FAIL if_rsp: got vld=%b id=%0d ppn=%h found=%b ps=%0d idx=%h, want 1 0 12345 1 12 0",
               rsp_valid, rsp_id, rsp_ppn, rsp_found, rsp_ps, rsp_index);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL if_rsp_no_hold: got vld=%b, want 0", rsp_valid);
    end
  endtask

  task automatic test_starvation();
    // Winners in {if,mem,srch} order: M M M I M M M I
    logic [23:0] pat = {3'b010, 3'b010, 3'b010, 3'b100, 3'b010, 3'b010, 3'b010, 3'b100};
    logic [2:0]  exp_g;
    logic [2:0]  prev_g = 3'b000;
    tick();
    if_req = 1'b1; if_vppn = 19'h00020; if_va_bit12 = 1'b0;
    mem_req = 1'b1; mem_vppn = 19'h00030; mem_va_bit12 = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (rsp_valid !== 1'b1
            || rsp_id !== ((prev_g == 3'b100) ? 2'd0 : 2'd1)
            || rsp_ppn !== ((prev_g == 3'b100) ? 20'h12325 : 20'h12304)) begin
          errors++;
          $display("FAIL starve_rsp cyc%0d: got vld=%b id=%0d ppn=%h for winner %b",
                   i, rsp_valid, rsp_id, rsp_ppn, prev_g);
        end
      end
      if (i < 8) begin
        exp_g = pat[23-3*i -: 3];
        checks++;
        if ({if_gnt, mem_gnt, srch_gnt} !== exp_g) begin
          errors++;
          $display("FAIL starve_gnt cyc%0d: got %b%b%b, want %b", i, if_gnt, mem_gnt, srch_gnt, exp_g);
        end
        prev_g = exp_g;
        tick();
      end
    end
    tick();
    if_req = 1'b0; mem_req = 1'b0;
    tick();
  endtask

  task automatic test_srch_priority();
    tick();
    if_req = 1'b1; if_vppn = 19'h00020; if_va_bit12 = 1'b1;
    mem_req = 1'b1; mem_vppn = 19'h00030; mem_va_bit12 = 1'b1;
    @(negedge clk);
    checks++;
    if ({if_gnt, mem_gnt, srch_gnt} !== 3'b010) begin
      errors++;
      $display("FAIL srch_pre_mem: got %b%b%b, want 010", if_gnt, mem_gnt, srch_gnt);
    end
    tick();
    srch_req = 1'b1; srch_vppn = 19'h00040;
    @(negedge clk);
    checks++;
    if ({if_gnt, mem_gnt, srch_gnt} !== 3'b001 || s_vppn !== 19'h00040 || s_va_bit12 !== 1'b0) begin
      errors++;
      $display("FAIL srch_gnt: got gnt=%b%b%b vppn=%h b12=%b, want 001 00040 0",
               if_gnt, mem_gnt, srch_gnt, s_vppn, s_va_bit12);
    end
    tick();
    srch_req = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_ppn !== 20'h123E5) begin
      errors++;
      $display("FAIL srch_rsp: got vld=%b id=%0d ppn=%h, want 1 2 123e5", rsp_valid, rsp_id, rsp_ppn);
    end
    // starve_cnt held at 1 across the SRCH win: two more MEM wins, then IF.
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        tick();
        @(negedge clk);
      end
      checks++;
      if ({if_gnt, mem_gnt, srch_gnt} !== ((i == 2) ? 3'b100 : 3'b010)) begin
        errors++;
        $display("FAIL srch_starve_hold cyc%0d: got %b%b%b, want %b",
                 i, if_gnt, mem_gnt, srch_gnt, (i == 2) ? 3'b100 : 3'b010);
      end
    end
    tick();
    if_req = 1'b0; mem_req = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    tick();
    if_req = 1'b1; if_vppn = 19'h00010; if_va_bit12 = 1'b0;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL flush_if_gnt: got %b, want 1", if_gnt);
    end
    tick();
    if_req = 1'b0; flush = 1'b1; mem_req = 1'b1; mem_vppn = 19'h00030;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || {if_gnt, mem_gnt, srch_gnt} !== 3'b000) begin
      errors++;
      $display("FAIL flush_if_squash: got vld=%b gnt=%b%b%b, want 0 000",
               rsp_valid, if_gnt, mem_gnt, srch_gnt);
    end
    tick();
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_gnt !== 1'b1) begin
      errors++;
      $display("FAIL flush_mem_after: got %b, want 1", mem_gnt);
    end
    tick();
    mem_req = 1'b0; srch_req = 1'b1; srch_vppn = 19'h00040;
    @(negedge clk);
    checks++;
    if (srch_gnt !== 1'b1) begin
      errors++;
      $display("FAIL flush_srch_gnt: got %b, want 1", srch_gnt);
    end
    tick();
    srch_req = 1'b0; flush = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin
      errors++;
      $display("FAIL flush_srch_keep: got vld=%b id=%0d, want 1 2", rsp_valid, rsp_id);
    end
    tick();
    flush = 1'b0;
  endtask

  task automatic test_busy();
    tick();
    mem_req = 1'b1; mem_vppn = 19'h00030; mem_va_bit12 = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_gnt !== 1'b1) begin
      errors++;
      $display("FAIL busy_pre_gnt: got %b, want 1", mem_gnt);
    end
    tick();
    tlb_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({if_gnt, mem_gnt, srch_gnt} !== 3'b000) begin
        errors++;
        $display("FAIL busy_no_gnt cyc%0d: got %b%b%b, want 000", i, if_gnt, mem_gnt, srch_gnt);
      end
      if (i == 0) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_ppn !== 20'h12304) begin
          errors++;
          $display("FAIL busy_inflight: got vld=%b id=%0d ppn=%h, want 1 1 12304",
                   rsp_valid, rsp_id, rsp_ppn);
        end
      end
      tick();
      if (i == 3) tlb_busy = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (mem_gnt !== 1'b1) begin
      errors++;
      $display("FAIL busy_release_gnt: got %b, want 1", mem_gnt);
    end
    tick();
    mem_req = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin
      errors++;
      $display("FAIL busy_release_rsp: got vld=%b id=%0d, want 1 1", rsp_valid, rsp_id);
    end
  endtask

  task automatic test_reset_mid();
    tick();
    srch_req = 1'b1; srch_vppn = 19'h00040;
    tick();
    srch_req = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin
      errors++;
      $display("FAIL reset_mid_pre: got vld=%b id=%0d, want 1 2", rsp_valid, rsp_id);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_ppn !== 20'h0) begin
      errors++;
      $display("FAIL reset_mid_drop: got vld=%b id=%0d ppn=%h, want 0 0 0", rsp_valid, rsp_id, rsp_ppn);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_if_hit();
    test_starvation();
    test_srch_priority();
    test_flush();
    test_busy();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
